// File: rtl/ibuff.sv
// Instruction buffer: fetches one 64-byte line in 16-byte regions from the I-cache
// and presents it to decode. Handles resteers, line changes and fetch faults.
module ibuff #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            resteer,
  input  logic [XLEN-1:0] resteer_target,
  input  logic            d1_advance,
  input  logic [XLEN-1:0] d1_next_pc,
  output logic            ic_req_valid,
  output logic [XLEN-1:0] ic_req_addr,
  input  logic            ic_req_ready,
  input  logic            ic_rsp_valid,
  input  logic [127:0]    ic_rsp_data,
  input  logic            ic_rsp_exception,
  output logic [511:0]    IBuff_out,
  output logic [3:0]      IBuff_valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic            exception_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [1:0]      next_region_q;
  logic [3:0]      valid_q;
  logic            inflight_q;
  logic            drop_q;
  logic            exc_q;
  logic [127:0]    region_q [4];

  logic            line_change;
  logic [XLEN-1:0] new_pc;
  logic            req_fire;
  logic            rsp_take;
  logic            rsp_write;
  logic            still_pending;

  // Response byte j lands at line byte 16k+j, which sits at the top of the region.
  function automatic logic [127:0] to_line_order(input logic [127:0] rsp);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      r[127-8*j -: 8] = rsp[8*j +: 8];
    end
    return r;
  endfunction

  assign ic_req_valid    = (state_q == REQ) && !drop_q;
  assign ic_req_addr     = {pc_q[XLEN-1:6], next_region_q, 4'b0000};
  assign IBuff_out       = {region_q[0], region_q[1], region_q[2], region_q[3]};
  assign IBuff_valid_out = valid_q;
  assign pc_out          = pc_q;
  assign exception_out   = exc_q;

  always_comb begin
    new_pc        = resteer ? resteer_target : d1_next_pc;
    line_change   = resteer || (d1_advance && (d1_next_pc[XLEN-1:6] != pc_q[XLEN-1:6]));
    req_fire      = ic_req_valid && ic_req_ready;
    rsp_take      = ic_rsp_valid && inflight_q;
    // A response coinciding with a line change belongs to the old line.
    rsp_write     = rsp_take && !drop_q && !line_change;
    // A request the cache still owes us after this edge must be discarded on arrival.
    still_pending = req_fire || (inflight_q && !ic_rsp_valid);
  end

  always_comb begin
    state_d = state_q;
    if (line_change) begin
      state_d = REQ;
    end else begin
      case (state_q)
        IDLE: if (!exc_q) state_d = REQ;
        REQ:  if (req_fire) state_d = WAIT;
        WAIT: if (rsp_write) begin
          state_d = (ic_rsp_exception || (next_region_q == 2'd3)) ? HOLD : REQ;
        end
        HOLD: state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      next_region_q <= '0;
      valid_q       <= '0;
      inflight_q    <= 1'b0;
      drop_q        <= 1'b0;
      exc_q         <= 1'b0;
      for (int k = 0; k < 4; k++) region_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (line_change) begin
        pc_q          <= new_pc;
        valid_q       <= '0;
        exc_q         <= 1'b0;
        next_region_q <= new_pc[5:4];
        inflight_q    <= still_pending;
        drop_q        <= still_pending;
      end else begin
        if (d1_advance) pc_q <= d1_next_pc;
        if (req_fire) inflight_q <= 1'b1;
        if (rsp_take) begin
          inflight_q <= 1'b0;
          drop_q     <= 1'b0;
        end
        if (rsp_write) begin
          region_q[next_region_q] <= to_line_order(ic_rsp_data);
          valid_q[next_region_q]  <= 1'b1;
          if (ic_rsp_exception) exc_q <= 1'b1;
          else next_region_q <= next_region_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ibuff.sv
// Bench for ibuff: I-cache responder plus a line-level reference model, hand-written
// corner sequences, a table of line-change vectors and a randomized soak.
module tb_ibuff;

  logic         clk = 1'b0;
  logic         rst;
  logic         resteer;
  logic [31:0]  resteer_target;
  logic         d1_advance;
  logic [31:0]  d1_next_pc;
  logic         ic_req_valid;
  logic [31:0]  ic_req_addr;
  logic         ic_req_ready;
  logic         ic_rsp_valid;
  logic [127:0] ic_rsp_data;
  logic         ic_rsp_exception;
  logic [511:0] IBuff_out;
  logic [3:0]   IBuff_valid_out;
  logic [31:0]  pc_out;
  logic         exception_out;

  ibuff #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .resteer(resteer), .resteer_target(resteer_target),
    .d1_advance(d1_advance), .d1_next_pc(d1_next_pc),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data), .ic_rsp_exception(ic_rsp_exception),
    .IBuff_out(IBuff_out), .IBuff_valid_out(IBuff_valid_out), .pc_out(pc_out),
    .exception_out(exception_out)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] DEAD = {4{32'hDEAD_BEEF}};

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          delay;
  } pend_t;

  typedef struct {
    bit          rs;
    logic [31:0] pc;
    logic [31:0] first;
    logic [3:0]  valid;
    int          nreq;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // cache responder state and policy
  pend_t       q[$];
  logic [31:0] req_log[$];
  int          ready_mode = 0;
  int          lat_max    = 0;
  bit          lat_rand   = 0;
  logic [31:0] exc_addr   = 32'hFFFF_FFFF;
  bit          exc_rand   = 0;
  bit          force_stale = 0;

  // reference model of what decode should see
  logic [31:0]  m_pc;
  logic [3:0]   m_valid;
  logic [127:0] m_data [4];
  bit           m_exc;
  int           m_next;
  logic [1:0]   m_start;
  int           stall;

  vec_t vt[7];

  function automatic logic [127:0] gen(input logic [31:0] a);
    return {a ^ 32'h1357_9BDF, ~a, a * 32'd3 + 32'd1, a ^ 32'hA5A5_0000};
  endfunction

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_valid = '0; m_exc = 0; m_next = 0; m_start = '0; stall = 0;
    for (int k = 0; k < 4; k++) m_data[k] = '0;
  endtask

  task automatic post_checks();
    logic [3:0]   mask;
    logic [127:0] exp_r;
    bit           full;
    chk("pc_out", pc_out, m_pc);
    chk("valid", IBuff_valid_out, m_valid);
    chk("exception", exception_out, m_exc);
    for (int k = 0; k < 4; k++) begin
      if (m_valid[k]) begin
        for (int i = 0; i < 16; i++) exp_r[127-8*i -: 8] = m_data[k][8*i +: 8];
        chk("region_data", IBuff_out[511-128*k -: 128], exp_r);
      end
    end
    mask = 4'b1111 << m_start;
    full = m_exc || (m_valid == mask);
    if (!full && q.size() == 0 && !ic_req_valid) stall++;
    else stall = 0;
    chk("no_fetch_stall", (stall > 1), 1'b0);
  endtask

  task automatic tick();
    logic         rv, rexc, fire, lc;
    logic [127:0] rd;
    logic [31:0]  faddr, npc;
    pend_t        h;
    int           rk;
    rv = 0; rexc = 0; rd = '0;
    if (force_stale) begin
      rv = 1; rd = DEAD;
    end else if (q.size() > 0 && q[0].delay == 0) begin
      h    = q[0];
      rv   = 1;
      rd   = h.stale ? DEAD : gen(h.addr);
      rexc = !h.stale && ((h.addr == exc_addr) || (exc_rand && $urandom_range(0, 15) == 0));
    end
    ic_rsp_valid = rv; ic_rsp_data = rd; ic_rsp_exception = rexc;
    case (ready_mode)
      0:       ic_req_ready = 1'b1;
      1:       ic_req_ready = 1'($urandom_range(0, 1));
      default: ic_req_ready = 1'b0;
    endcase
    fire  = ic_req_valid && ic_req_ready;
    faddr = ic_req_addr;
    npc   = resteer ? resteer_target : d1_next_pc;
    lc    = resteer || (d1_advance && (d1_next_pc[31:6] != m_pc[31:6]));
    if (!rst && ic_req_valid) begin
      chk("req_allowed", (q.size() == 0) && !m_exc && (m_next < 4), 1'b1);
      chk("req_addr", ic_req_addr, {m_pc[31:6], m_next[1:0], 4'b0000});
    end
    @(posedge clk); #1;
    if (rst) begin
      q.delete();
      model_reset();
    end else begin
      if (rv && !force_stale) begin
        h = q.pop_front();
        if (!h.stale && !lc) begin
          rk = int'(h.addr[5:4]);
          m_valid[rk] = 1'b1;
          m_data[rk]  = rd;
          if (rexc) m_exc = 1;
          else m_next = rk + 1;
        end
      end else if (q.size() > 0) begin
        h = q.pop_front();
        if (h.delay > 0) h.delay--;
        q.push_front(h);
      end
      if (fire) begin
        h.addr = faddr; h.stale = 0;
        h.delay = lat_rand ? $urandom_range(0, lat_max) : lat_max;
        q.push_back(h);
        req_log.push_back(faddr);
      end
      if (lc) begin
        for (int i = 0; i < q.size(); i++) begin
          h = q[i]; h.stale = 1; q[i] = h;
        end
        m_pc = npc; m_valid = '0; m_exc = 0;
        m_next = int'(npc[5:4]); m_start = npc[5:4];
      end else if (d1_advance) begin
        m_pc = d1_next_pc;
      end
      post_checks();
    end
    force_stale = 0; resteer = 0; d1_advance = 0;
  endtask

  task automatic run_until_quiet(input int max);
    bit done;
    done = 0;
    for (int i = 0; i < max; i++) begin
      if (q.size() == 0 && !ic_req_valid) begin
        done = 1;
        break;
      end
      tick();
    end
    chk("quiet_timeout", done, 1'b1);
  endtask

  task automatic do_resteer(input logic [31:0] t);
    resteer = 1; resteer_target = t;
    tick();
  endtask

  task automatic do_adv(input logic [31:0] p);
    d1_advance = 1; d1_next_pc = p;
    tick();
  endtask

  initial begin
    logic [31:0] held_addr;
    int          r;

    vt[0] = '{rs: 1'b1, pc: 32'h1028, first: 32'h1020, valid: 4'b1100, nreq: 2};
    vt[1] = '{rs: 1'b1, pc: 32'h2000, first: 32'h2000, valid: 4'b1111, nreq: 4};
    vt[2] = '{rs: 1'b1, pc: 32'h303C, first: 32'h3030, valid: 4'b1000, nreq: 1};
    vt[3] = '{rs: 1'b1, pc: 32'h4014, first: 32'h4010, valid: 4'b1110, nreq: 3};
    vt[4] = '{rs: 1'b0, pc: 32'h4018, first: 32'h0000, valid: 4'b1110, nreq: 0};
    vt[5] = '{rs: 1'b0, pc: 32'h4040, first: 32'h4040, valid: 4'b1111, nreq: 4};
    vt[6] = '{rs: 1'b0, pc: 32'h40A4, first: 32'h40A0, valid: 4'b1100, nreq: 2};

    rst = 1; resteer = 0; resteer_target = '0; d1_advance = 0; d1_next_pc = '0;
    ic_req_ready = 0; ic_rsp_valid = 0; ic_rsp_data = '0; ic_rsp_exception = 0;
    model_reset();

    // reset state, first request timing, full line from address 0
    repeat (3) tick();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_valid", IBuff_valid_out, 4'b0);
    chk("rst_ibuff", IBuff_out, 512'b0);
    chk("rst_exc", exception_out, 1'b0);
    chk("rst_req_valid", ic_req_valid, 1'b0);
    rst = 0;
    req_log.delete();
    tick();
    chk("first_req_valid", ic_req_valid, 1'b1);
    chk("first_req_addr", ic_req_addr, 32'h0);
    run_until_quiet(40);
    chk("line0_nreq", req_log.size(), 4);
    for (int n = 0; n < req_log.size(); n++) chk("line0_req", req_log[n], 32'(n * 16));
    chk("line0_valid", IBuff_valid_out, 4'b1111);
    repeat (5) tick();
    chk("hold_no_req", req_log.size(), 4);
    chk("hold_req_valid", ic_req_valid, 1'b0);

    // same-line advances keep the line; crossing the line restarts the fetch
    req_log.delete();
    do_adv(32'h4);
    do_adv(32'h8);
    chk("adv_same_valid", IBuff_valid_out, 4'b1111);
    chk("adv_same_pc", pc_out, 32'h8);
    do_adv(32'h3C);
    do_adv(32'h40);
    chk("adv_cross_valid", IBuff_valid_out, 4'b0000);
    chk("adv_cross_req", ic_req_valid, 1'b1);
    chk("adv_cross_addr", ic_req_addr, 32'h40);
    run_until_quiet(40);

    // table of line-change vectors
    for (int v = 0; v < 7; v++) begin
      req_log.delete();
      if (vt[v].rs) do_resteer(vt[v].pc);
      else do_adv(vt[v].pc);
      run_until_quiet(40);
      chk("vec_pc", pc_out, vt[v].pc);
      chk("vec_valid", IBuff_valid_out, vt[v].valid);
      chk("vec_nreq", req_log.size(), vt[v].nreq);
      for (int n = 0; n < req_log.size(); n++) chk("vec_req", req_log[n], vt[v].first + 32'(16 * n));
    end

    // ready held low: request stays put
    ready_mode = 2;
    do_resteer(32'h6000);
    held_addr = ic_req_addr;
    chk("stall_addr", held_addr, 32'h6000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", ic_req_valid, 1'b1);
      chk("stall_addr_hold", ic_req_addr, held_addr);
    end
    ready_mode = 0;
    run_until_quiet(40);

    // resteer while a request is in flight: stale data is discarded
    lat_max = 3;
    do_resteer(32'h7000);
    tick();
    req_log.delete();
    do_resteer(32'h8010);
    lat_max = 0;
    run_until_quiet(40);
    chk("stale_next_req", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h8010);
    chk("stale_valid", IBuff_valid_out, 4'b1110);

    // fetch fault on region 1
    exc_addr = 32'h5010;
    req_log.delete();
    do_resteer(32'h5010);
    run_until_quiet(40);
    chk("fault_exc", exception_out, 1'b1);
    chk("fault_valid", IBuff_valid_out, 4'b0010);
    repeat (6) tick();
    chk("fault_no_req", req_log.size(), 1);
    do_resteer(32'h5020);
    chk("fault_cleared", exception_out, 1'b0);
    exc_addr = 32'hFFFF_FFFF;
    run_until_quiet(40);

    // reset mid-transaction, stale response after reset is ignored
    lat_max = 2;
    do_resteer(32'h9000);
    tick();
    rst = 1;
    tick();
    rst = 0;
    lat_max = 0;
    force_stale = 1;
    req_log.delete();
    tick();
    chk("rst_stale_valid", IBuff_valid_out, 4'b0000);
    run_until_quiet(40);
    chk("rst_refetch_n", req_log.size(), 4);
    chk("rst_refetch_0", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h0);

    // randomized soak against the model
    ready_mode = 1; lat_rand = 1; lat_max = 3; exc_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        resteer = 1; resteer_target = $urandom & 32'h0000_0FFF;
        if (r < 2) begin
          d1_advance = 1; d1_next_pc = $urandom & 32'h0000_0FFF;
        end
      end else if (r < 24) begin
        d1_advance = 1;
        d1_next_pc = ($urandom_range(0, 9) < 7) ? m_pc + 32'd4 : ($urandom & 32'h0000_0FFF);
      end
      tick();
    end
    ready_mode = 0; lat_rand = 0; lat_max = 0; exc_rand = 0;
    run_until_quiet(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
